// File: rtl/jtag_bscan_sys_if.sv
// JTAG serial port bundle (TMS/TDI toward the TAP, TDO/TDO_EN back to the tester).
// The tester side uses the master modport; the TAP uses the slave modport.
interface jtag_bscan_sys_if;
  logic TMS;
  logic TDI;
  logic TDO;
  logic TDO_EN;

  modport master (
    output TMS,
    output TDI,
    input  TDO,
    input  TDO_EN
  );

  modport slave (
    input  TMS,
    input  TDI,
    output TDO,
    output TDO_EN
  );
endinterface

// File: rtl/jtag_bscan_sys.sv
// IEEE 1149.1-style TAP with IR, BYPASS, optional IDCODE and an N_IN+N_OUT boundary-scan register.
// Define JTAG_IDCODE_EN to add the 32-bit ID register and make IDCODE the reset instruction.
module jtag_bscan_sys #(
  parameter int unsigned N_IN     = 5,
  parameter int unsigned N_OUT    = 4,
  parameter int unsigned IR_W     = 4,
  parameter logic [31:0] ID_VALUE = 32'h1000_0A01
) (
  input  logic              TCK,
  input  logic              TRST_N,
  jtag_bscan_sys_if.slave   jtag,
  input  logic [N_IN-1:0]   from_SYS_to_BSR,
  output logic [N_IN-1:0]   from_BSR_to_CL,
  input  logic [N_OUT-1:0]  from_CL_to_BSR,
  output logic [N_OUT-1:0]  from_BSR_to_SYS
);

  localparam int unsigned N_BSR = N_IN + N_OUT;

  localparam logic [IR_W-1:0] OP_EXTEST  = IR_W'(0);
  localparam logic [IR_W-1:0] OP_SAMPLE  = IR_W'(1);
  localparam logic [IR_W-1:0] OP_IDCODE  = IR_W'(2);
  localparam logic [IR_W-1:0] OP_INTEST  = IR_W'(3);
  localparam logic [IR_W-1:0] OP_BYPASS  = '1;
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_W-1:0] RST_IR = OP_IDCODE;
`else
  localparam logic [IR_W-1:0] RST_IR = OP_BYPASS;
`endif

  if (IR_W < 2) begin : g_bad_ir_w
    $error("jtag_bscan_sys: IR_W must be at least 2");
  end
  if (ID_VALUE[0] != 1'b1) begin : g_bad_id_value
    $error("jtag_bscan_sys: ID_VALUE bit 0 must be 1");
  end

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_e;

  tap_state_e state_q, state_d;

  logic [IR_W-1:0]  ir_shift_q, ir_shift_d;
  logic [IR_W-1:0]  ir_q, ir_d;
  logic [N_BSR-1:0] bsr_q, bsr_d;
  logic [N_BSR-1:0] upd_q, upd_d;
  logic             byp_q, byp_d;
  logic             tdo_q, tdo_d;
  logic             tdo_en_q, tdo_en_d;

`ifdef JTAG_IDCODE_EN
  logic [31:0]      id_q, id_d;
`endif

  logic             sel_bsr;
  logic             sel_id;
  logic             sel_byp;
  logic             dr_lsb;

  // ---------------------------------------------------------------------------
  // TAP controller
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of process ordering.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first; a path that leaves
  // a variable unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      state_d = jtag.TMS ? TLR      : RTI;
      RTI:      state_d = jtag.TMS ? SEL_DR   : RTI;
      SEL_DR:   state_d = jtag.TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = jtag.TMS ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_d = jtag.TMS ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_d = jtag.TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = jtag.TMS ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_d = jtag.TMS ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_d = jtag.TMS ? SEL_DR   : RTI;
      SEL_IR:   state_d = jtag.TMS ? TLR      : CAP_IR;
      CAP_IR:   state_d = jtag.TMS ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_d = jtag.TMS ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_d = jtag.TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = jtag.TMS ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_d = jtag.TMS ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_d = jtag.TMS ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction decode: any opcode not listed falls through to BYPASS
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_bsr = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE) || (ir_q == OP_INTEST);
`ifdef JTAG_IDCODE_EN
    sel_id  = (ir_q == OP_IDCODE);
`else
    sel_id  = 1'b0;
`endif
    sel_byp = !sel_bsr && !sel_id;
  end

  always_comb begin
    dr_lsb = byp_q;
    if (sel_bsr) begin
      dr_lsb = bsr_q[0];
    end
`ifdef JTAG_IDCODE_EN
    else if (sel_id) begin
      dr_lsb = id_q[0];
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Instruction and data registers
  // ---------------------------------------------------------------------------
  always_comb begin
    ir_shift_d = ir_shift_q;
    ir_d       = ir_q;
    bsr_d      = bsr_q;
    upd_d      = upd_q;
    byp_d      = byp_q;
`ifdef JTAG_IDCODE_EN
    id_d       = id_q;
`endif

    case (state_q)
      CAP_DR: begin
        if (sel_bsr) bsr_d = {from_SYS_to_BSR, from_CL_to_BSR};
        if (sel_byp) byp_d = 1'b0;
`ifdef JTAG_IDCODE_EN
        if (sel_id)  id_d  = ID_VALUE;
`endif
      end
      SHIFT_DR: begin
        if (sel_bsr) bsr_d = {jtag.TDI, bsr_q[N_BSR-1:1]};
        if (sel_byp) byp_d = jtag.TDI;
`ifdef JTAG_IDCODE_EN
        if (sel_id)  id_d  = {jtag.TDI, id_q[31:1]};
`endif
      end
      UPD_DR: begin
        if (sel_bsr) upd_d = bsr_q;
      end
      CAP_IR:   ir_shift_d = IR_CAPTURE;
      SHIFT_IR: ir_shift_d = {jtag.TDI, ir_shift_q[IR_W-1:1]};
      UPD_IR:   ir_d       = ir_shift_q;
      default: ;
    endcase

    // Entering Test-Logic-Reset by TMS has the same effect as TRST_N.
    if (state_d == TLR) begin
      ir_d  = RST_IR;
      upd_d = '0;
    end
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_shift_q <= '0;
      ir_q       <= RST_IR;
      bsr_q      <= '0;
      upd_q      <= '0;
      byp_q      <= 1'b0;
    end else begin
      ir_shift_q <= ir_shift_d;
      ir_q       <= ir_d;
      bsr_q      <= bsr_d;
      upd_q      <= upd_d;
      byp_q      <= byp_d;
    end
  end

`ifdef JTAG_IDCODE_EN
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      id_q <= '0;
    end else begin
      id_q <= id_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // TDO launches on falling TCK so the tester can sample it on the next rising edge
  // ---------------------------------------------------------------------------
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    case (state_q)
      SHIFT_DR: begin
        tdo_d    = dr_lsb;
        tdo_en_d = 1'b1;
      end
      SHIFT_IR: begin
        tdo_d    = ir_shift_q[0];
        tdo_en_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign jtag.TDO    = tdo_q;
  assign jtag.TDO_EN = tdo_en_q;

  // ---------------------------------------------------------------------------
  // Pin/core muxing follows the active instruction combinationally
  // ---------------------------------------------------------------------------
  always_comb begin
    from_BSR_to_CL  = from_SYS_to_BSR;
    from_BSR_to_SYS = from_CL_to_BSR;
    if (ir_q == OP_EXTEST) begin
      from_BSR_to_SYS = upd_q[N_OUT-1:0];
    end else if (ir_q == OP_INTEST) begin
      from_BSR_to_CL  = upd_q[N_BSR-1:N_OUT];
      from_BSR_to_SYS = upd_q[N_OUT-1:0];
    end
  end

endmodule
